range_sum_ctrl: RTL and testbench
=================================

# range_sum_ctrl

Sequential front end for the combinational range adder `adder_comb`. It loads eight 4-bit operands serially over a valid/ready stream and packs them into the 32-bit operand bank. It then accepts range queries (M, m) over a second handshake and returns the registered sum of I[min..max] with valid/ready. `adder_comb` is the stage directly downstream of the bank; this block feeds its Iin/M/m inputs and consumes its Y.

## Interface
- NIB_W, 4, operand width
- NUM, 8, operands in bank
- IDX_W, 3, index width (log2 NUM)
- SUM_W, 8, result width
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  nibble stream valid
- in_ready  out  1  nibble stream ready
- in_data  in  NIB_W  nibble; first accepted goes to slot 0 (Iin[3:0])
- reload  in  1  single-cycle pulse, restarts bank loading
- q_valid  in  1  query valid
- q_ready  out  1  query ready
- q_M, q_m  in  IDX_W each  range endpoints, either order
- r_valid  out  1  result valid
- r_ready  in  1  result ready
- r_sum  out  SUM_W  sum of I[min(M,m)] .. I[max(M,m)] inclusive
- err  out  1  sticky self-check mismatch (see Configuration)

## Operation
- FSM states:
  - LOAD: in_ready=1; each in_valid&&in_ready writes in_data to slot cnt, then cnt++. After the 8th accept the next state is READY.
  - READY: q_ready=1. q_valid&&q_ready latches M/m and moves to EVAL. reload clears cnt and moves to LOAD without clearing the bank.
  - EVAL: one cycle. `adder_comb` is driven from the bank and the M/m registers; Y is captured into r_sum at the end of the cycle, then RESP.
  - RESP: r_valid=1. On r_valid&&r_ready go to READY.
- reload and q_valid asserted together in READY: reload wins, q_ready=0 that cycle.
- reload outside READY is ignored. in_valid outside LOAD is ignored (in_ready=0).
- Queries are not accepted until a full bank of 8 nibbles has loaded.
- Arithmetic: max sum is 8×15=120, so it fits SUM_W with no overflow and no saturation. M==m returns a single operand.

## Timing
- Reset (rst high at a clk edge): state LOAD, cnt=0, bank=0, M/m regs=0, r_sum=0, r_valid=0, err=0. in_ready=1 and q_ready=0 from the first cycle after release.
- in_ready and q_ready are combinational decodes of state only, never of in_valid or q_valid.
- Load throughput is one nibble per cycle. READY is entered the cycle after the 8th accept edge.
- Query latency: query accepted at edge k; EVAL during cycle k+1; r_valid=1 and r_sum valid from edge k+2.
- Back-to-back queries take a minimum of 3 cycles each.
- r_sum is stable while r_valid=1 and r_ready=0. q_ready=0 throughout EVAL and RESP.
- rst mid-operation (any state) aborts and returns to reset values at that edge. An outstanding result is dropped.

## Configuration
- RANGE_SUM_CHECK_EN defined: in EVAL, a behavioural loop recomputes the range sum from the bank and compares it with `adder_comb` Y. On mismatch err is set and held until rst.
- RANGE_SUM_CHECK_EN undefined: the checker is not compiled and err is tied to 0. The port list is identical in both builds.

## Structure
- Package range_sum_pkg holds:
  - the state enum (LOAD, READY, EVAL, RESP)
  - constants NIB_W, NUM, IDX_W, SUM_W
- One sub-module, `adder_comb`, instantiated as-is: Iin = packed bank with slot i at [4i+3:4i], M/m from the latched registers, Y to the r_sum capture register.
- Bank, cnt, M/m and r_sum registers live in this block.

## Test plan
- Load 1,2,3,4,5,6,7,8 (Iin=32'h87654321). Query M=6,m=6 → r_sum=7. Query M=0,m=4 → r_sum=15. Query M=5,m=4 → r_sum=11. r_valid rises exactly 2 cycles after each query accept.
- Load all 4'hF. Query M=7,m=0 → r_sum=8'd120 (no overflow). Query M=0,m=7 → same result.
- Hold r_ready=0 for 3 cycles in RESP → r_valid=1 and r_sum unchanged, q_ready=0. Then r_ready=1 → READY next cycle, q_ready=1.
- rst after 5 nibbles → cnt=0, state LOAD, r_valid=0. Load 8 fresh nibbles, then query M=2,m=2 → returns the fresh slot-2 value.
- In READY, assert reload and q_valid together → no query accepted, in_ready=1 next cycle. in_valid pulses before 8 accepts leave q_ready=0.
- With RANGE_SUM_CHECK_EN defined, run 100 random banks and queries → err stays 0 and every r_sum matches the bench model.

Source files
------------

// File: rtl/range_sum_pkg.sv
// Shared types and constants for the range_sum_ctrl slice.
// range_sum() is the independent reference sum used by the optional checker.
package range_sum_pkg;

  localparam int NIB_W = 4;
  localparam int NUM   = 8;
  localparam int IDX_W = 3;
  localparam int SUM_W = 8;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    READY = 2'd1,
    EVAL  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Walks the slots in order and adds the ones inside the inclusive range.
  function automatic logic [SUM_W-1:0] range_sum(
    input logic [NUM*NIB_W-1:0] bank,
    input logic [IDX_W-1:0]     a,
    input logic [IDX_W-1:0]     b
  );
    logic [IDX_W-1:0] lo;
    logic [IDX_W-1:0] hi;
    logic [SUM_W-1:0] acc;
    lo  = (a < b) ? a : b;
    hi  = (a < b) ? b : a;
    acc = '0;
    for (int i = 0; i < NUM; i++) begin
      if (i >= int'(lo) && i <= int'(hi)) begin
        acc = acc + SUM_W'(bank[i*NIB_W +: NIB_W]);
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/range_sum_ctrl_adder_comb.sv
// adder_comb: combinational sum of the nibbles I[min(M,m)]..I[max(M,m)].
// Slot i of Iin sits at [4i+3:4i]; endpoints may arrive in either order.
module adder_comb
  import range_sum_pkg::*;
(
  input  logic [NUM*NIB_W-1:0] Iin,
  input  logic [IDX_W-1:0]     M,
  input  logic [IDX_W-1:0]     m,
  output logic [SUM_W-1:0]     Y
);

  logic [IDX_W-1:0] lo;
  logic [IDX_W-1:0] hi;
  logic [NUM-1:0]   sel;

  assign lo = (M < m) ? M : m;
  assign hi = (M < m) ? m : M;

  // Build a slot-select mask first, then add the selected nibbles.
  always_comb begin
    sel = '0;
    Y   = '0;
    for (int i = 0; i < NUM; i++) begin
      sel[i] = (IDX_W'(i) >= lo) && (IDX_W'(i) <= hi);
    end
    for (int i = 0; i < NUM; i++) begin
      if (sel[i]) begin
        Y = Y + SUM_W'(Iin[i*NIB_W +: NIB_W]);
      end
    end
  end

endmodule

// File: rtl/range_sum_ctrl.sv
// range_sum_ctrl: loads eight nibbles serially, then serves range-sum queries.
// Optional self-check of adder_comb enabled by defining RANGE_SUM_CHECK_EN.
module range_sum_ctrl
  import range_sum_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NIB_W-1:0] in_data,
  input  logic             reload,
  input  logic             q_valid,
  output logic             q_ready,
  input  logic [IDX_W-1:0] q_M,
  input  logic [IDX_W-1:0] q_m,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [SUM_W-1:0] r_sum,
  output logic             err
);

  state_t                 state;
  logic [IDX_W-1:0]       cnt;
  logic [NUM*NIB_W-1:0]   bank;
  logic [IDX_W-1:0]       idx_a;
  logic [IDX_W-1:0]       idx_b;
  logic [SUM_W-1:0]       y;

  assign in_ready = (state == LOAD);
  // A reload in READY takes priority, so the query side is held off that cycle.
  assign q_ready  = (state == READY) && !reload;

  adder_comb u_adder (
    .Iin (bank),
    .M   (idx_a),
    .m   (idx_b),
    .Y   (y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      cnt     <= '0;
      bank    <= '0;
      idx_a   <= '0;
      idx_b   <= '0;
      r_sum   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            bank[{cnt, 2'b00} +: NIB_W] <= in_data;
            cnt                         <= cnt + 1'b1;
            if (cnt == IDX_W'(NUM - 1)) begin
              state <= READY;
            end
          end
        end
        READY: begin
          if (reload) begin
            cnt   <= '0;
            state <= LOAD;
          end else if (q_valid) begin
            idx_a <= q_M;
            idx_b <= q_m;
            state <= EVAL;
          end
        end
        EVAL: begin
          r_sum   <= y;
          r_valid <= 1'b1;
          state   <= RESP;
        end
        RESP: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            state   <= READY;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef RANGE_SUM_CHECK_EN
  // Sticky flag: any disagreement with the reference sum stays visible until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == EVAL && range_sum(bank, idx_a, idx_b) != y) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_range_sum_ctrl.sv
// Directed and random checks for range_sum_ctrl using immediate assertions.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_range_sum_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       reload;
  logic       q_valid;
  logic       q_ready;
  logic [2:0] q_M;
  logic [2:0] q_m;
  logic       r_valid;
  logic       r_ready;
  logic [7:0] r_sum;
  logic       err;

  int assertCount = 0;
  int failCount   = 0;

  range_sum_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .reload   (reload),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .q_M      (q_M),
    .q_m      (q_m),
    .r_valid  (r_valid),
    .r_ready  (r_ready),
    .r_sum    (r_sum),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] modelSum(input logic [31:0] word,
                                          input logic [2:0] a, input logic [2:0] b);
    logic [7:0] acc;
    int lo;
    int hi;
    lo  = (a < b) ? int'(a) : int'(b);
    hi  = (a < b) ? int'(b) : int'(a);
    acc = 8'd0;
    for (int i = lo; i <= hi; i++) acc = acc + {4'd0, word[i*4 +: 4]};
    return acc;
  endfunction

  task automatic loadNibbles(input logic [31:0] word, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      in_valid = 1'b1;
      in_data  = word[i*4 +: 4];
      stepClk();
    end
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b,
                               input logic [7:0] expected, input string tag);
    checkOutput({tag, "_qready_pre"}, {31'd0, q_ready}, 32'd1);
    q_valid = 1'b1;
    q_M     = a;
    q_m     = b;
    r_ready = 1'b0;
    stepClk();
    q_valid = 1'b0;
    checkOutput({tag, "_eval_rvalid"}, {31'd0, r_valid}, 32'd0);
    checkOutput({tag, "_eval_qready"}, {31'd0, q_ready}, 32'd0);
    stepClk();
    checkOutput({tag, "_resp_rvalid"}, {31'd0, r_valid}, 32'd1);
    checkOutput({tag, "_sum"}, {24'd0, r_sum}, {24'd0, expected});
    r_ready = 1'b1;
    stepClk();
    r_ready = 1'b0;
    checkOutput({tag, "_done_rvalid"}, {31'd0, r_valid}, 32'd0);
    checkOutput({tag, "_done_qready"}, {31'd0, q_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] word;
    logic [2:0]  ra;
    logic [2:0]  rb;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; reload = 1'b0;
    q_valid = 1'b0; q_M = '0; q_m = '0; r_ready = 1'b0;
    stepClk();
    stepClk();
    rst = 1'b0;
    stepClk();
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_q_ready", {31'd0, q_ready}, 32'd0);
    checkOutput("rst_r_valid", {31'd0, r_valid}, 32'd0);
    checkOutput("rst_r_sum", {24'd0, r_sum}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);

    // Ascending bank 1..8
    word = 32'h87654321;
    loadNibbles(word, 0, 7);
    checkOutput("load7_q_ready", {31'd0, q_ready}, 32'd0);
    loadNibbles(word, 7, 1);
    checkOutput("load8_in_ready", {31'd0, in_ready}, 32'd0);
    applyStimulus(3'd6, 3'd6, 8'd7, "q66");
    applyStimulus(3'd0, 3'd4, 8'd15, "q04");
    applyStimulus(3'd5, 3'd4, 8'd11, "q54");

    // All-F bank: full range is the maximum sum
    rst = 1'b1;
    stepClk();
    rst = 1'b0;
    word = 32'hFFFFFFFF;
    loadNibbles(word, 0, 8);
    applyStimulus(3'd7, 3'd0, 8'd120, "q70");
    applyStimulus(3'd0, 3'd7, 8'd120, "q07");

    // Result held while r_ready stays low
    q_valid = 1'b1; q_M = 3'd1; q_m = 3'd2;
    stepClk();
    q_valid = 1'b0;
    stepClk();
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold_r_valid", {31'd0, r_valid}, 32'd1);
      checkOutput("hold_r_sum", {24'd0, r_sum}, 32'd30);
      checkOutput("hold_q_ready", {31'd0, q_ready}, 32'd0);
      stepClk();
    end
    r_ready = 1'b1;
    stepClk();
    r_ready = 1'b0;
    checkOutput("hold_release_q_ready", {31'd0, q_ready}, 32'd1);
    checkOutput("hold_release_r_valid", {31'd0, r_valid}, 32'd0);

    // in_valid in READY must not touch the bank
    in_valid = 1'b1; in_data = 4'h0;
    stepClk();
    in_valid = 1'b0;
    applyStimulus(3'd3, 3'd3, 8'd15, "ignore_in");

    // reload beats a simultaneous query
    reload = 1'b1; q_valid = 1'b1; q_M = 3'd0; q_m = 3'd7;
    #1;
    checkOutput("reload_q_ready", {31'd0, q_ready}, 32'd0);
    stepClk();
    reload = 1'b0; q_valid = 1'b0;
    checkOutput("reload_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reload_r_valid", {31'd0, r_valid}, 32'd0);
    word = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      loadNibbles(word, i, 1);
      stepClk();
      checkOutput("gap_q_ready", {31'd0, q_ready}, 32'd0);
    end
    loadNibbles(word, 3, 5);
    applyStimulus(3'd0, 3'd7, 8'd36, "reload_full");

    // rst after 5 nibbles aborts the load
    reload = 1'b1;
    stepClk();
    reload = 1'b0;
    word = 32'h9ABCDEF0;
    loadNibbles(word, 0, 5);
    rst = 1'b1;
    stepClk();
    rst = 1'b0;
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midrst_r_valid", {31'd0, r_valid}, 32'd0);
    word = 32'h6B1D5C3A;
    loadNibbles(word, 0, 7);
    checkOutput("midrst_load7_q_ready", {31'd0, q_ready}, 32'd0);
    loadNibbles(word, 7, 1);
    applyStimulus(3'd2, 3'd2, 8'd12, "midrst_q22");

    // Random banks and queries against the bench model
    for (int n = 0; n < 100; n++) begin
      word = $urandom;
      ra   = 3'($urandom_range(0, 7));
      rb   = 3'($urandom_range(0, 7));
      reload = 1'b1;
      stepClk();
      reload = 1'b0;
      loadNibbles(word, 0, 8);
      applyStimulus(ra, rb, modelSum(word, ra, rb), "rand");
    end
    checkOutput("final_err", {31'd0, err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
